perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_cnt_defs_pkg.sv | 16 +
 rtl/count_channel.sv | 74 +++++++
 rtl/perf_counter_bank.sv | 82 ++++++++
 tb/tb_perf_counter_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/perf_cnt_defs_pkg.sv
// Shared definitions for the perf counter bank: saturate-mode encodings and select-width helper.
// Latency: n/a (constants only). Backpressure: n/a.
package perf_cnt_defs;

    localparam int unsigned SAT_WRAP = 0;
    localparam int unsigned SAT_HOLD = 1;

    // Select width is clog2 with a floor of one bit so a single channel still has a select port.
    function automatic int unsigned sel_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/count_channel.sv
// Single event counter with clear/load/increment priority, wrap or saturate, sticky overflow (PERF_CNT_OVF_IRQ_EN).
// Latency: count visible one cycle after the event. Backpressure: none, every enabled cycle is counted.
module count_channel
    import perf_cnt_defs::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned SATURATE   = SAT_WRAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  inc_i,
    input  logic                  ovf_clr_i,
    output logic [DATA_WIDTH-1:0] cnt_o,
    output logic                  ovf_o
);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                  at_max;
    logic                  ovf_set;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_data_i;
        end else if (inc_i) begin
            if (at_max) begin
                ovf_set = 1'b1;
                cnt_d   = (SATURATE == SAT_HOLD) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifdef PERF_CNT_OVF_IRQ_EN
    logic ovf_q, ovf_d;

    // A new overflow on the same edge as a clear request must survive.
    assign ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_set ^ ovf_clr_i;
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with snapshot shadows, registered read mux and sticky overflow/irq (PERF_CNT_OVF_IRQ_EN).
// Latency: rd_data one cycle after rd_sel; shadows capture pre-update counts. Backpressure: none.
module perf_counter_bank
    import perf_cnt_defs::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 4,
    parameter int unsigned SATURATE   = SAT_WRAP
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   enable,
    input  logic                                clear,
    input  logic                                load_en,
    input  logic [sel_width(NUM_CH)-1:0]        load_sel,
    input  logic [DATA_WIDTH-1:0]               load_data,
    input  logic                                snap,
    input  logic [sel_width(NUM_CH)-1:0]        rd_sel,
    output logic [DATA_WIDTH-1:0]               rd_data,
    input  logic [NUM_CH-1:0]                   ovf_clr,
    output logic [NUM_CH-1:0]                   ovf,
    output logic                                irq
);

    localparam int unsigned SW = sel_width(NUM_CH);

    logic [DATA_WIDTH-1:0] cnt      [NUM_CH];
    logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
    logic [NUM_CH-1:0]     ch_load;
    logic [NUM_CH-1:0]     ovf_w;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range selects match no channel, so such loads are dropped.
        assign ch_load[g] = load_en && (load_sel == SW'(g));

        count_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (clear),
            .load_i      (ch_load[g]),
            .load_data_i (load_data),
            .inc_i       (enable[g]),
            .ovf_clr_i   (ovf_clr[g]),
            .cnt_o       (cnt[g]),
            .ovf_o       (ovf_w[g])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q[g] <= '0;
            end else if (snap) begin
                shadow_q[g] <= cnt[g];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SW'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ovf     = ovf_w;
    assign irq     = |ovf_w;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrapping 8-bit 4-channel bank and a saturating 8-bit 3-channel bank on shared stimulus.
// Overflow expectations follow PERF_CNT_OVF_IRQ_EN.
module tb_perf_counter_bank;

`ifdef PERF_CNT_OVF_IRQ_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] enable;
    logic       clear;
    logic       load_en;
    logic [1:0] load_sel;
    logic [7:0] load_data;
    logic       snap;
    logic [1:0] rd_sel;
    logic [3:0] ovf_clr;

    logic [7:0] rd_w, rd_s;
    logic [3:0] ovf_w;
    logic [2:0] ovf_s;
    logic       irq_w, irq_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.DATA_WIDTH(8), .NUM_CH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load_en(load_en),
        .load_sel(load_sel), .load_data(load_data), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_w), .ovf_clr(ovf_clr), .ovf(ovf_w), .irq(irq_w)
    );

    perf_counter_bank #(.DATA_WIDTH(8), .NUM_CH(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable[2:0]), .clear(clear), .load_en(load_en),
        .load_sel(load_sel), .load_data(load_data), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_s), .ovf_clr(ovf_clr[2:0]), .ovf(ovf_s), .irq(irq_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] val);
        load_en = 1'b1; load_sel = ch; load_data = val;
        tick();
        load_en = 1'b0;
    endtask

    task automatic inc(input logic [1:0] ch);
        enable = 4'b0001 << ch;
        tick();
        enable = '0;
    endtask

    task automatic read_ch(input logic [1:0] ch);
        snap = 1'b1;
        tick();
        snap = 1'b0; rd_sel = ch;
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = '0; clear = 1'b0; load_en = 1'b0; load_sel = '0;
        load_data = '0; snap = 1'b0; rd_sel = '0; ovf_clr = '0;
        tick(); tick();
        check("reset_rd_w", rd_w, 0);
        check("reset_rd_s", rd_s, 0);
        check("reset_ovf_w", ovf_w, 0);
        check("reset_irq_w", irq_w, 0);
        rst = 1'b0;

        // Build up non-zero state, then pulse reset mid-cycle.
        load(2'd1, 8'hFF);
        snap = 1'b1; enable = 4'b0010;
        tick();
        snap = 1'b0; enable = '0; rd_sel = 2'd1;
        tick();
        check("pre_rst_rd_w", rd_w, 8'hFF);
        check("pre_rst_rd_s", rd_s, 8'hFF);
        check("pre_rst_ovf_w", ovf_w, OVF_ON ? 4'h2 : 4'h0);
        check("pre_rst_ovf_s", ovf_s, OVF_ON ? 3'h2 : 3'h0);
        check("pre_rst_irq_w", irq_w, OVF_ON);
        enable = 4'b0001;
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst_rd_w", rd_w, 0);
        check("async_rst_ovf_w", ovf_w, 0);
        check("async_rst_irq_w", irq_w, 0);
        check("async_rst_irq_s", irq_s, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        enable = '0;
        read_ch(2'd0);
        check("post_rst_count_w", rd_w, 8'd5);
        check("post_rst_count_s", rd_s, 8'd5);

        // Wrap versus saturate around all-ones.
        load(2'd2, 8'hFE);
        inc(2'd2);
        check("wrap_pre_ovf_w", ovf_w, 0);
        read_ch(2'd2);
        check("wrap_ff_w", rd_w, 8'hFF);
        inc(2'd2);
        check("wrap_edge_ovf_w", ovf_w, OVF_ON ? 4'h4 : 4'h0);
        check("sat_edge_ovf_s", ovf_s, OVF_ON ? 3'h4 : 3'h0);
        read_ch(2'd2);
        check("wrap_00_w", rd_w, 8'h00);
        inc(2'd2);
        read_ch(2'd2);
        check("wrap_01_w", rd_w, 8'h01);
        check("sat_hold_s", rd_s, 8'hFF);
        ovf_clr = 4'b0100; enable = 4'b0100;
        tick();
        ovf_clr = '0; enable = '0;
        check("ovf_clr_w", ovf_w, 0);
        check("ovf_clr_irq_w", irq_w, 0);
        check("ovf_set_wins_s", ovf_s, OVF_ON ? 3'h4 : 3'h0);
        check("ovf_set_wins_irq_s", irq_s, OVF_ON);

        // Snap, load and enable together on channel 3.
        load(2'd3, 8'd7);
        snap = 1'b1; load_en = 1'b1; load_sel = 2'd3; load_data = 8'd100; enable = 4'b1000;
        tick();
        snap = 1'b0; load_en = 1'b0; enable = '0; rd_sel = 2'd3;
        tick();
        check("snap_preload_w", rd_w, 8'd7);
        check("rd_out_of_range_s", rd_s, 0);
        read_ch(2'd3);
        check("load_beats_inc_w", rd_w, 8'd100);
        read_ch(2'd2);
        check("ch2_after_loads_w", rd_w, 8'd2);
        check("bad_load_sel_s", rd_s, 8'hFF);

        // Clear with all enables leaves overflow flags and shadows alone.
        load(2'd0, 8'hFF);
        inc(2'd0);
        load(2'd1, 8'h33);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        clear = 1'b1; enable = 4'b1111;
        tick();
        clear = 1'b0; enable = '0;
        check("clear_keeps_ovf_w", ovf_w, OVF_ON ? 4'h1 : 4'h0);
        check("clear_keeps_ovf_s", ovf_s, OVF_ON ? 3'h5 : 3'h0);
        rd_sel = 2'd1;
        tick();
        check("clear_keeps_shadow_w", rd_w, 8'h33);
        check("clear_keeps_shadow_s", rd_s, 8'h33);
        read_ch(2'd1);
        check("clear_ch1_w", rd_w, 0);
        check("clear_ch1_s", rd_s, 0);
        read_ch(2'd3);
        check("clear_ch3_w", rd_w, 0);
        check("rd_sel_num_ch_s", rd_s, 0);
        read_ch(2'd2);
        check("clear_ch2_w", rd_w, 0);
        check("clear_ch2_s", rd_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
